// File: rtl/av_copy_master_if.sv
// Avalon-MM bus bundle between the copy engine (master) and the SOC data bus (slave).
interface av_copy_master_if;
  logic [31:0] o_AV_Address;
  logic [3:0]  o_AV_ByteEn;
  logic        o_AV_Read;
  logic        o_AV_Write;
  logic [31:0] o_AV_WriteData;
  logic [31:0] i_AV_ReadData;
  logic        i_AV_WaitRequest;

  modport master (
    output o_AV_Address,
    output o_AV_ByteEn,
    output o_AV_Read,
    output o_AV_Write,
    output o_AV_WriteData,
    input  i_AV_ReadData,
    input  i_AV_WaitRequest
  );

  modport slave (
    input  o_AV_Address,
    input  o_AV_ByteEn,
    input  o_AV_Read,
    input  o_AV_Write,
    input  o_AV_WriteData,
    output i_AV_ReadData,
    output i_AV_WaitRequest
  );
endinterface

// File: rtl/av_copy_master.sv
// Avalon-MM DMA copy engine: one read then one write per 32-bit word, with
// stall handling, fixed read latency and a sticky abort that never splits a word.
module av_copy_master #(
  parameter int READ_LATENCY = 1,
  parameter int COUNT_BITS   = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_Abort,
  input  logic [31:0]           i_SrcAddr,
  input  logic [31:0]           i_DstAddr,
  input  logic [COUNT_BITS-1:0] i_WordCount,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Aborted,
  output logic [COUNT_BITS-1:0] o_Remaining,
  av_copy_master_if.master      av
);

  localparam int LAT_BITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [31:0]           data_q, data_d;
  logic [COUNT_BITS-1:0] rem_q, rem_d;
  logic                  abort_q, abort_d;
  logic [LAT_BITS-1:0]   lat_q, lat_d;
  logic [COUNT_BITS-1:0] rem_dec;
  logic                  abort_now;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      abort_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    rem_d     = rem_q;
    abort_d   = abort_q;
    lat_d     = lat_q;
    rem_dec   = rem_q - COUNT_BITS'(1);
    abort_now = abort_q | i_Abort;

    o_Busy            = (state_q != IDLE);
    o_Done            = 1'b0;
    o_Aborted         = 1'b0;
    av.o_AV_Address   = '0;
    av.o_AV_ByteEn    = '0;
    av.o_AV_Read      = 1'b0;
    av.o_AV_Write     = 1'b0;
    av.o_AV_WriteData = '0;

    // The abort flag is sticky and only listens while a transfer is running.
    if (state_q != IDLE) begin
      abort_d = abort_now;
    end

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          src_d   = i_SrcAddr & 32'hFFFF_FFFC;
          dst_d   = i_DstAddr & 32'hFFFF_FFFC;
          rem_d   = i_WordCount;
          abort_d = 1'b0;
          state_d = (i_WordCount == '0) ? DONE : RD_REQ;
        end
      end

      RD_REQ: begin
        // A pending abort is deliberately ignored here: the read must complete.
        av.o_AV_Read    = 1'b1;
        av.o_AV_Address = src_q;
        if (!av.i_AV_WaitRequest) begin
          lat_d   = LAT_BITS'(READ_LATENCY);
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (lat_q <= LAT_BITS'(1)) begin
          data_d  = av.i_AV_ReadData;
          state_d = WR_REQ;
        end else begin
          lat_d = lat_q - LAT_BITS'(1);
        end
      end

      WR_REQ: begin
        av.o_AV_Write     = 1'b1;
        av.o_AV_Address   = dst_q;
        av.o_AV_WriteData = data_q;
        av.o_AV_ByteEn    = 4'hF;
        if (!av.i_AV_WaitRequest) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_dec;
          state_d = ((rem_dec == '0) || abort_now) ? DONE : RD_REQ;
        end
      end

      DONE: begin
        o_Done    = 1'b1;
        o_Aborted = abort_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_Remaining = rem_q;

endmodule

// File: tb/tb_av_copy_master.sv
// Randomised scoreboard bench: two engines (read latency 1 and 3) share control stimulus,
// each with its own stalling slave; a monitor checks them against a word-level copy model.
module tb_av_copy_master;
  localparam int CB = 16;

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    int          n;
  } desc_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort_in;
  logic [31:0]   src_in;
  logic [31:0]   dst_in;
  logic [CB-1:0] cnt_in;

  logic          busy_a, done_a, aborted_a;
  logic          busy_b, done_b, aborted_b;
  logic [CB-1:0] rem_a, rem_b;

  av_copy_master_if bus_a ();
  av_copy_master_if bus_b ();

  av_copy_master #(.READ_LATENCY(1), .COUNT_BITS(CB)) u_dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Abort(abort_in),
    .i_SrcAddr(src_in), .i_DstAddr(dst_in), .i_WordCount(cnt_in),
    .o_Busy(busy_a), .o_Done(done_a), .o_Aborted(aborted_a), .o_Remaining(rem_a),
    .av(bus_a)
  );

  av_copy_master #(.READ_LATENCY(3), .COUNT_BITS(CB)) u_dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Abort(abort_in),
    .i_SrcAddr(src_in), .i_DstAddr(dst_in), .i_WordCount(cnt_in),
    .o_Busy(busy_b), .o_Done(done_b), .o_Aborted(aborted_b), .o_Remaining(rem_b),
    .av(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave memory: explicit preloads, otherwise an address-derived pattern.
  logic [31:0] mem [bit [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  // Stall configuration per phase: -1 means random 0..2 per request.
  int rd_cfg = 0;
  int wr_cfg = 0;

  // ---------------- slave model ----------------
  int          sl_stall [2] = '{-1, -1};
  int          sl_lat   [2] = '{0, 0};
  logic [31:0] sl_addr  [2];

  function automatic int pick(input int cfg);
    if (cfg < 0) return int'($urandom_range(0, 2));
    return cfg;
  endfunction

  task automatic slave_step(input int i, input int lat, input logic rdv, input logic wrv,
                            input logic [31:0] addr, output logic w, output logic [31:0] d);
    d = $urandom;
    if (sl_lat[i] > 0) begin
      sl_lat[i] = sl_lat[i] - 1;
      if (sl_lat[i] == 0) d = mem_rd(sl_addr[i]);
    end
    w = 1'b0;
    if (rdv || wrv) begin
      if (sl_stall[i] < 0) sl_stall[i] = rdv ? pick(rd_cfg) : pick(wr_cfg);
      if (sl_stall[i] > 0) begin
        w = 1'b1;
        sl_stall[i] = sl_stall[i] - 1;
      end else begin
        sl_stall[i] = -1;
        if (rdv) begin
          sl_lat[i]  = lat;
          sl_addr[i] = addr;
        end
      end
    end else begin
      sl_stall[i] = -1;
      w = 1'($urandom_range(0, 1));
    end
  endtask

  always @(negedge clk) begin
    logic        w;
    logic [31:0] d;
    slave_step(0, 1, bus_a.o_AV_Read, bus_a.o_AV_Write, bus_a.o_AV_Address, w, d);
    bus_a.i_AV_WaitRequest = w;
    bus_a.i_AV_ReadData    = d;
    slave_step(1, 3, bus_b.o_AV_Read, bus_b.o_AV_Write, bus_b.o_AV_Address, w, d);
    bus_b.i_AV_WaitRequest = w;
    bus_b.i_AV_ReadData    = d;
  end

  // ---------------- scoreboard / monitor ----------------
  desc_t q_a[$];
  desc_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  bit          act      [2] = '{0, 0};
  bit          rst_pend [2] = '{0, 0};
  bit          rem_zero [2] = '{1, 1};
  bit          prev_rs  [2] = '{0, 0};
  bit          prev_ws  [2] = '{0, 0};
  bit          ab       [2] = '{0, 0};
  int          st_cyc   [2];
  int          nw       [2];
  int          limit    [2];
  int          k        [2];
  int          r        [2];
  int          stalls   [2];
  int          lat_left [2] = '{0, 0};
  logic [31:0] msrc     [2];
  logic [31:0] mdst     [2];
  logic [31:0] prev_addr[2];
  logic [31:0] prev_wd  [2];

  task automatic chk(input bit ok, input string name, input int i,
                     input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cyc, got, want);
  endtask

  task automatic mon_step(input int i, input int lat, input logic rdv, input logic wrv,
                          input logic wt, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic bsy, input logic dn,
                          input logic abd, input logic [CB-1:0] rm);
    desc_t       dsc;
    logic [31:0] ea;
    logic [31:0] ed;
    int          exp_cyc;
    bit          exp_dn;
    logic [4:0]  flags;
    flags = {bsy, rdv, wrv, dn, abd};

    if (rst_pend[i]) begin
      chk(flags == 5'b0 && be == 4'h0 && addr == 32'h0 && wd == 32'h0, "reset_outputs", i,
          {27'b0, flags}, 32'h0);
      chk(rm == '0, "reset_remaining", i, 32'(rm), 32'h0);
      rst_pend[i] = 1'b0;
    end

    if (rst) begin
      act[i] = 1'b0; rst_pend[i] = 1'b1; rem_zero[i] = 1'b1;
      prev_rs[i] = 1'b0; prev_ws[i] = 1'b0; lat_left[i] = 0;
    end else if (!act[i]) begin
      chk(flags == 5'b0 && be == 4'h0, "idle_quiet", i, {27'b0, flags}, 32'h0);
      if (rem_zero[i]) chk(rm == '0, "idle_remaining", i, 32'(rm), 32'h0);
      if (start && ((i == 0) ? q_a.size() : q_b.size()) > 0) begin
        if (i == 0) dsc = q_a.pop_front();
        else        dsc = q_b.pop_front();
        act[i] = 1'b1; st_cyc[i] = cyc; nw[i] = dsc.n; limit[i] = dsc.n;
        msrc[i] = dsc.s & 32'hFFFF_FFFC; mdst[i] = dsc.d & 32'hFFFF_FFFC;
        ab[i] = 1'b0; k[i] = 0; r[i] = 0; stalls[i] = 0; lat_left[i] = 0;
        prev_rs[i] = 1'b0; prev_ws[i] = 1'b0; rem_zero[i] = 1'b0;
      end
    end else begin
      chk(bsy && (dn || !abd), "busy", i, {27'b0, flags}, 32'h10);
      chk(!(rdv && wrv), "rd_wr_exclusive", i, {30'b0, rdv, wrv}, 32'h0);
      chk(be == (wrv ? 4'hF : 4'h0), "byteen", i, 32'(be), wrv ? 32'hF : 32'h0);
      chk(rm == CB'(nw[i] - k[i]), "remaining", i, 32'(rm), 32'(nw[i] - k[i]));
      if (prev_rs[i]) chk(rdv && addr == prev_addr[i], "rd_stable", i, addr, prev_addr[i]);
      if (prev_ws[i]) chk(wrv && addr == prev_addr[i] && wd == prev_wd[i], "wr_stable", i,
                          wd, prev_wd[i]);
      if (lat_left[i] > 0) begin
        chk(!rdv && !wrv, "rd_wait_no_request", i, {30'b0, rdv, wrv}, 32'h0);
        lat_left[i] = lat_left[i] - 1;
      end
      // An abort lets the word in flight finish, then stops.
      if (abort_in && k[i] < limit[i] && !ab[i]) begin
        ab[i] = 1'b1;
        if (k[i] + 1 < limit[i]) limit[i] = k[i] + 1;
      end
      exp_cyc = st_cyc[i] + 1 + limit[i] * (2 + lat) + stalls[i];
      exp_dn  = (k[i] == limit[i]) && (cyc == exp_cyc);
      if (dn || exp_dn) begin
        chk(dn && exp_dn, "done_timing", i, 32'(cyc - st_cyc[i]), 32'(exp_cyc - st_cyc[i]));
        chk(abd == ab[i], "aborted", i, 32'(abd), 32'(ab[i]));
        act[i] = 1'b0;
      end else if (cyc > st_cyc[i] + 400) begin
        chk(1'b0, "timeout", i, 32'(k[i]), 32'(limit[i]));
        act[i] = 1'b0;
      end else begin
        if (rdv) begin
          if (wt) stalls[i]++;
          else begin
            ea = msrc[i] + 32'(4 * r[i]);
            chk(addr == ea && r[i] < limit[i], "rd_addr", i, addr, ea);
            r[i]++;
            lat_left[i] = lat;
          end
        end
        if (wrv) begin
          if (wt) stalls[i]++;
          else begin
            ea = mdst[i] + 32'(4 * k[i]);
            ed = mem_rd(msrc[i] + 32'(4 * k[i]));
            chk(addr == ea && k[i] < r[i], "wr_addr", i, addr, ea);
            chk(wd == ed, "wr_data", i, wd, ed);
            k[i]++;
          end
        end
        prev_rs[i] = rdv && wt; prev_ws[i] = wrv && wt;
        prev_addr[i] = addr; prev_wd[i] = wd;
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    mon_step(0, 1, bus_a.o_AV_Read, bus_a.o_AV_Write, bus_a.i_AV_WaitRequest,
             bus_a.o_AV_Address, bus_a.o_AV_ByteEn, bus_a.o_AV_WriteData,
             busy_a, done_a, aborted_a, rem_a);
    mon_step(1, 3, bus_b.o_AV_Read, bus_b.o_AV_Write, bus_b.i_AV_WaitRequest,
             bus_b.o_AV_Address, bus_b.o_AV_ByteEn, bus_b.o_AV_WriteData,
             busy_b, done_b, aborted_b, rem_b);
  end

  // ---------------- stimulus ----------------
  task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input int n);
    desc_t x;
    x.s = s; x.d = d; x.n = n;
    q_a.push_back(x);
    q_b.push_back(x);
  endtask

  task automatic run_txn(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int ab_at, input int st2_at);
    @(negedge clk);
    src_in = s; dst_in = d; cnt_in = CB'(n); start = 1'b1;
    push_desc(s, d, n);
    $display("txn: src=%h dst=%h count=%0d abort_at=%0d", s, d, n, ab_at);
    for (int t = 1; t < 600; t++) begin
      @(negedge clk);
      start    = 1'b0;
      abort_in = (t == ab_at);
      src_in   = $urandom; dst_in = $urandom; cnt_in = CB'($urandom);
      if (t == st2_at) start = 1'b1;
      if (t > 2 && !act[0] && !act[1] && !abort_in && !start) break;
    end
    start = 1'b0; abort_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort_in = 1'b0;
    src_in = '0; dst_in = '0; cnt_in = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int j = 0; j < 4; j++) mem[32'h100 + 32'(4 * j)] = 32'hA0 + 32'(j);
    rd_cfg = 0; wr_cfg = 0;
    run_txn(32'h100, 32'h200, 4, 0, 0);
    run_txn(32'h300, 32'h400, 0, 0, 0);
    rd_cfg = 3; wr_cfg = 2;
    run_txn(32'h100, 32'h800, 2, 0, 0);
    rd_cfg = 0; wr_cfg = 0;
    run_txn(32'h1000, 32'h2000, 8, 5, 3);
    run_txn(32'hFFFF_FFF8, 32'h0000_5000, 3, 0, 0);
    run_txn(32'h0000_0403, 32'hFFFF_FFFA, 3, 0, 0);

    for (int j = 0; j < 24; j++) begin
      rd_cfg = (j % 2 == 0) ? -1 : 0;
      wr_cfg = (j % 3 == 0) ? 0 : -1;
      run_txn($urandom, $urandom, int'($urandom_range(0, 6)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0, 0);
    end

    // Reset while both engines sit in a long write stall.
    rd_cfg = 0; wr_cfg = 12;
    @(negedge clk);
    src_in = 32'h40; dst_in = 32'h80; cnt_in = CB'(3); start = 1'b1;
    push_desc(32'h40, 32'h80, 3);
    $display("txn: src=00000040 dst=00000080 count=3 reset during write stall");
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_cfg = 0; wr_cfg = 0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
